// File: rtl/pd_pluse_pkg.sv
// Shared types and sizes for the pulse-generator parameter loader.
package pd_pluse_pkg;

    localparam int DEPTH    = 16;
    localparam int CHOICE_W = 4;
    localparam int DATA_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_START
    } state_t;

endpackage

// File: rtl/pd_pluse_loader_if.sv
// Host-side write/go signals and pulse-generator side outputs of the loader.
interface pd_pluse_loader_if;
    import pd_pluse_pkg::*;

    logic                host_we;
    logic [CHOICE_W-1:0] host_addr;
    logic [DATA_W-1:0]   host_wdata;
    logic                cfg_go;
    logic [CHOICE_W-1:0] pd_pluse_choice;
    logic [DATA_W-1:0]   pd_pluse_data;
    logic                pd_pluse_load;
    logic                pluse_start;
    logic                busy;
    logic                done;
    logic                wr_err;

    modport master (
        output host_we, host_addr, host_wdata, cfg_go,
        input  pd_pluse_choice, pd_pluse_data, pd_pluse_load,
        input  pluse_start, busy, done, wr_err
    );

    modport slave (
        input  host_we, host_addr, host_wdata, cfg_go,
        output pd_pluse_choice, pd_pluse_data, pd_pluse_load,
        output pluse_start, busy, done, wr_err
    );

endinterface

// File: rtl/pd_pluse_prienc.sv
// Lowest-set-bit priority encoder over the pending mask.
import pd_pluse_pkg::*;

module pd_pluse_prienc (
    input  logic [DEPTH-1:0]    mask,
    output logic [CHOICE_W-1:0] idx,
    output logic                any
);

    // scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CHOICE_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pd_pluse_loader.sv
// Streams pending parameter-table entries to the pulse generator, then fires
// a single start pulse.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | host may write the table; waiting for cfg_go
// ST_SETUP  | choice/data presented, load low (1 cycle)
// ST_STROBE | load high for LOAD_HOLD cycles, pending bit cleared at end
// ST_GAP    | LOAD_GAP idle cycles after a strobe
// ST_START  | pluse_start and done high for one cycle
import pd_pluse_pkg::*;

module pd_pluse_loader #(
    parameter int LOAD_HOLD = 2,
    parameter int LOAD_GAP  = 1
) (
    input logic               clk_sys,
    input logic               rst_n,
    pd_pluse_loader_if.slave  bus
);

    localparam logic [3:0] HOLD_M1 = 4'(LOAD_HOLD - 1);
    localparam logic [3:0] GAP_M1  = 4'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);

    state_t              state;
    logic [3:0]          cnt;
    logic [DATA_W-1:0]   tbl [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic [DEPTH-1:0]    pending_nx;
    logic                we_ok;
    logic                last_strobe;
    logic [CHOICE_W-1:0] sel_idx;
    logic                sel_any;
    logic [DATA_W-1:0]   sel_data;

    logic [CHOICE_W-1:0] choice_q;
    logic [DATA_W-1:0]   data_q;
    logic                load_q;
    logic                start_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_err_q;

    // Selection looks at the mask as it will be next cycle, so a write landing
    // together with cfg_go, or a bit cleared in the last strobe cycle, is
    // already accounted for when the next SETUP is entered.
    always_comb begin
        we_ok       = bus.host_we && (state == ST_IDLE);
        last_strobe = (state == ST_STROBE) && (cnt == 4'd0);
        pending_nx  = pending;
        if (we_ok)
            pending_nx[bus.host_addr] = 1'b1;
        if (last_strobe)
            pending_nx[choice_q] = 1'b0;
        sel_data = (we_ok && (bus.host_addr == sel_idx)) ? bus.host_wdata : tbl[sel_idx];
    end

    pd_pluse_prienc u_prienc (
        .mask (pending_nx),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // parameter table, writable only while idle
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
        end else if (we_ok) begin
            tbl[bus.host_addr] <= bus.host_wdata;
        end
    end

    // pending mask follows the combinational next-state view
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nx;
    end

    // flag host writes that arrive while a stream is in progress
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            wr_err_q <= 1'b0;
        else
            wr_err_q <= bus.host_we && (state != ST_IDLE);
    end

    // sequencing FSM with registered outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            choice_q <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_go) begin
                        busy_q <= 1'b1;
                        if (sel_any) begin
                            state    <= ST_SETUP;
                            choice_q <= sel_idx;
                            data_q   <= sel_data;
                        end else begin
                            state   <= ST_START;
                            start_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state  <= ST_STROBE;
                    load_q <= 1'b1;
                    cnt    <= HOLD_M1;
                end
                ST_STROBE: begin
                    if (cnt == 4'd0) begin
                        load_q <= 1'b0;
                        if (LOAD_GAP > 0) begin
                            state <= ST_GAP;
                            cnt   <= GAP_M1;
                        end else if (sel_any) begin
                            state    <= ST_SETUP;
                            choice_q <= sel_idx;
                            data_q   <= sel_data;
                        end else begin
                            state   <= ST_START;
                            start_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 4'd0) begin
                        if (sel_any) begin
                            state    <= ST_SETUP;
                            choice_q <= sel_idx;
                            data_q   <= sel_data;
                        end else begin
                            state   <= ST_START;
                            start_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_START: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    load_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pd_pluse_choice = choice_q;
    assign bus.pd_pluse_data   = data_q;
    assign bus.pd_pluse_load   = load_q;
    assign bus.pluse_start     = start_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.wr_err          = wr_err_q;

endmodule

// File: tb/tb_pd_pluse_loader.sv
// Scoreboard bench for pd_pluse_loader: default-parameter instance checked by
// a queue-driven monitor, plus a LOAD_HOLD=1/LOAD_GAP=0 instance for the
// back-to-back sixteen-entry stream.
module tb_pd_pluse_loader;

    typedef struct {
        bit          is_start;
        logic [3:0]  ch;
        logic [15:0] d;
    } exp_t;

    logic clk_sys;
    logic rst_n;
    int   total;
    int   bad;
    int   n_start;
    int   exp_starts;

    exp_t        sbq[$];
    logic [15:0] mtbl [16];
    logic [15:0] mpend;

    pd_pluse_loader_if bus ();
    pd_pluse_loader_if bus2 ();

    pd_pluse_loader dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    pd_pluse_loader #(.LOAD_HOLD(1), .LOAD_GAP(0)) dut2 (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus2)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    // reference model: table + pending set, each go streams pending in ascending order
    task automatic m_write(input logic [3:0] a, input logic [15:0] d);
        mtbl[a]  = d;
        mpend[a] = 1'b1;
    endtask

    task automatic m_go();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (mpend[i]) begin
                e.is_start = 1'b0;
                e.ch       = 4'(i);
                e.d        = mtbl[i];
                sbq.push_back(e);
            end
        end
        mpend      = '0;
        e.is_start = 1'b1;
        e.ch       = '0;
        e.d        = '0;
        sbq.push_back(e);
        exp_starts++;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++)
            mtbl[i] = '0;
        mpend = '0;
        sbq.delete();
        exp_starts = n_start;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        bus.host_we    = 1'b1;
        bus.host_addr  = a;
        bus.host_wdata = d;
        m_write(a, d);
        cyc();
        bus.host_we = 1'b0;
    endtask

    task automatic go();
        bus.cfg_go = 1'b1;
        m_go();
        cyc();
        bus.cfg_go = 1'b0;
    endtask

    task automatic wait_starts();
        int n = 0;
        while (n_start < exp_starts && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        check("start_count", 64'(n_start), 64'(exp_starts));
        cyc();
        @(negedge clk_sys);
        check("busy_after_start", 64'(bus.busy), 64'd0);
    endtask

    // monitor: pops the scoreboard on each load rising edge and each start
    bit   prev_load;
    int   load_len;
    exp_t cur;
    exp_t st;
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            prev_load = 1'b0;
            load_len  = 0;
        end else begin
            if (bus.pd_pluse_load) begin
                if (!prev_load) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_load", 64'd1, 64'd0);
                        cur.is_start = 1'b0;
                        cur.ch       = 'x;
                        cur.d        = 'x;
                    end else begin
                        cur = sbq.pop_front();
                        check("load_vs_start_order", 64'(cur.is_start), 64'd0);
                    end
                end
                check("load_choice_data", {44'd0, bus.pd_pluse_choice, bus.pd_pluse_data},
                      {44'd0, cur.ch, cur.d});
                load_len++;
            end else if (prev_load) begin
                check("load_hold_len", 64'(load_len), 64'd2);
                load_len = 0;
            end
            if (bus.pluse_start) begin
                n_start++;
                if (sbq.size() == 0) begin
                    check("unexpected_start", 64'd1, 64'd0);
                end else begin
                    st = sbq.pop_front();
                    check("start_order", 64'(st.is_start), 64'd1);
                end
                check("done_with_start", 64'(bus.done), 64'd1);
            end else if (bus.done) begin
                check("done_without_start", 64'd1, 64'd0);
            end
            prev_load = bus.pd_pluse_load;
        end
    end

    logic [15:0] d2 [16];

    initial begin
        total = 0; bad = 0; n_start = 0; exp_starts = 0;
        bus.host_we = 0;  bus.host_addr = 0;  bus.host_wdata = 0;  bus.cfg_go = 0;
        bus2.host_we = 0; bus2.host_addr = 0; bus2.host_wdata = 0; bus2.cfg_go = 0;
        rst_n = 1'b0;
        m_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk_sys);
        check("reset_outputs", {bus.pd_pluse_choice, bus.pd_pluse_data, bus.pd_pluse_load,
              bus.pluse_start, bus.busy, bus.done, bus.wr_err}, 64'd0);
        check("reset_outputs2", {bus2.pd_pluse_choice, bus2.pd_pluse_data, bus2.pd_pluse_load,
              bus2.pluse_start, bus2.busy, bus2.done, bus2.wr_err}, 64'd0);
        cyc();

        // single entry, cycle-accurate timing relative to cfg_go at cycle 0
        host_write(4'd3, 16'h1234);
        go();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_sys);
            check($sformatf("timing_c%0d", k), {61'd0, bus.busy, bus.pd_pluse_load, bus.pluse_start},
                  {61'd0, (k <= 5) ? 1'b1 : 1'b0, (k == 2 || k == 3) ? 1'b1 : 1'b0,
                   (k == 5) ? 1'b1 : 1'b0});
        end
        cyc();

        // two entries written out of order stream lowest index first
        host_write(4'd9, 16'hAAAA);
        host_write(4'd2, 16'h5555);
        go();
        wait_starts();

        // empty mask goes straight to start
        cyc();
        go();
        @(negedge clk_sys);
        check("empty_go_c1", {61'd0, bus.busy, bus.pd_pluse_load, bus.pluse_start}, 64'b101);
        @(negedge clk_sys);
        check("empty_go_c2", {61'd0, bus.busy, bus.pd_pluse_load, bus.pluse_start}, 64'b000);
        cyc();

        // write during strobe is rejected and nothing new is sent later
        host_write(4'd4, 16'hBEEF);
        go();
        cyc();
        bus.host_we = 1'b1; bus.host_addr = 4'd5; bus.host_wdata = 16'h1111;
        cyc();
        bus.host_we = 1'b0;
        @(negedge clk_sys);
        check("wr_err_strobe", 64'(bus.wr_err), 64'd1);
        wait_starts();
        cyc();
        go();
        wait_starts();

        // reset in the second strobe cycle clears everything asynchronously
        cyc();
        host_write(4'd1, 16'h0101);
        host_write(4'd6, 16'h0606);
        go();
        cyc();
        cyc();
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.pd_pluse_choice, bus.pd_pluse_data, bus.pd_pluse_load,
              bus.pluse_start, bus.busy, bus.done, bus.wr_err}, 64'd0);
        m_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        go();
        @(negedge clk_sys);
        check("post_reset_start", {61'd0, bus.busy, bus.pd_pluse_load, bus.pluse_start}, 64'b101);
        wait_starts();

        // randomized write bursts, optional same-cycle write, optional rejected write
        for (int it = 0; it < 25; it++) begin
            int  nw;
            bit  same_wr;
            bit  busy_wr;
            nw      = $urandom_range(0, 4);
            same_wr = 1'($urandom_range(0, 1));
            busy_wr = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++)
                host_write(4'($urandom_range(0, 15)), 16'($urandom));
            bus.cfg_go = 1'b1;
            if (same_wr) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = 4'($urandom_range(0, 15));
                bus.host_wdata = 16'($urandom);
                m_write(bus.host_addr, bus.host_wdata);
            end
            m_go();
            cyc();
            bus.cfg_go  = 1'b0;
            bus.host_we = busy_wr;
            bus.host_addr  = 4'($urandom_range(0, 15));
            bus.host_wdata = 16'($urandom);
            cyc();
            bus.host_we = 1'b0;
            @(negedge clk_sys);
            check("rand_wr_err", 64'(bus.wr_err), 64'(busy_wr));
            wait_starts();
            cyc();
        end

        // back-to-back stream of all sixteen entries, one hold cycle, no gap
        for (int i = 15; i >= 0; i--) begin
            d2[i] = 16'($urandom);
            bus2.host_we    = 1'b1;
            bus2.host_addr  = 4'(i);
            bus2.host_wdata = d2[i];
            cyc();
        end
        bus2.host_we = 1'b0;
        bus2.cfg_go  = 1'b1;
        cyc();
        bus2.cfg_go = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            bit exp_ld;
            @(negedge clk_sys);
            exp_ld = (k >= 2 && k <= 32 && (k % 2) == 0);
            check($sformatf("b2b_c%0d", k), {62'd0, bus2.pd_pluse_load, bus2.pluse_start},
                  {62'd0, exp_ld, (k == 33) ? 1'b1 : 1'b0});
            if (exp_ld)
                check($sformatf("b2b_entry_c%0d", k), {44'd0, bus2.pd_pluse_choice, bus2.pd_pluse_data},
                      {44'd0, 4'((k - 2) / 2), d2[(k - 2) / 2]});
        end

        cyc();
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pd_pluse_loader.md
PD_PLUSE_LOADER -- requirements
Module: pd_pluse_loader

Interface
REQ-001 SHALL have parameter LOAD_HOLD, default 2: cycles pd_pluse_load is held high per entry, legal 1..15.
REQ-002 SHALL have parameter LOAD_GAP, default 1: idle cycles after each load strobe, legal 0..15.
REQ-003 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port host_we  in  1  write strobe into the parameter table.
REQ-006 SHALL have port host_addr  in  4  table index, equal to the pulse-choice code.
REQ-007 SHALL have port host_wdata  in  16  parameter word.
REQ-008 SHALL have port cfg_go  in  1  request to stream pending entries, then fire the pulse train.
REQ-009 SHALL have port pd_pluse_choice  out  4  parameter select presented to the pulse generator.
REQ-010 SHALL have port pd_pluse_data  out  16  parameter value presented to the pulse generator.
REQ-011 SHALL have port pd_pluse_load  out  1  load strobe to the pulse generator.
REQ-012 SHALL have port pluse_start  out  1  one-cycle start pulse to the pulse generator.
REQ-013 SHALL have port busy  out  1  high from the cycle after an accepted cfg_go through the START cycle.
REQ-014 SHALL have port done  out  1  one-cycle pulse coincident with pluse_start.
REQ-015 SHALL have port wr_err  out  1  one-cycle pulse when a host write is rejected.

Function
REQ-016 SHALL hold a 16x16 table plus a 16-bit pending mask; host_we in IDLE writes table[host_addr] and sets pending[host_addr].
REQ-017 SHALL reject host_we while busy: table and mask unchanged, wr_err high the next cycle.
REQ-018 SHALL include a same-cycle host_we and cfg_go in IDLE: the write lands and the entry is streamed.
REQ-019 SHALL use the FSM IDLE -> SETUP -> STROBE -> GAP -> (SETUP if pending remain, else START) -> IDLE; GAP is skipped when LOAD_GAP=0.
REQ-020 SHALL select, in SETUP, the lowest-index pending entry and drive pd_pluse_choice/pd_pluse_data from it with pd_pluse_load low (1 cycle).
REQ-021 SHALL assert pd_pluse_load for exactly LOAD_HOLD cycles in STROBE, with choice/data stable from SETUP to the end of STROBE.
REQ-022 SHALL clear the pending bit in the last STROBE cycle.
REQ-023 SHALL go IDLE -> START directly on cfg_go with an empty mask, giving pluse_start one cycle after cfg_go.
REQ-024 SHALL assert pluse_start and done for one cycle in START; busy drops the following cycle.
REQ-025 SHALL ignore cfg_go when not in IDLE; it is not queued.
REQ-026 SHALL hold choice/data at their last driven values outside SETUP/STROBE.
REQ-027 SHALL register all outputs (no combinational input-to-output path).

Reset
REQ-028 SHALL, on rst_n low at any time including mid-stream, immediately set: FSM=IDLE, table=0, pending=0, choice=0, data=0, load=0, pluse_start=0, busy=0, done=0, wr_err=0.
REQ-029 SHALL leave the first cfg_go after reset release with an empty mask, so it takes the REQ-023 path.

Structure
REQ-030 SHALL place the state enum, table depth (16), choice width (4) and data width (16) in shared package pd_pluse_pkg.
REQ-031 SHALL implement lowest-set-bit selection over the 16-bit pending mask as sub-module pd_pluse_prienc (outputs index and any-valid).

Verification
REQ-032 SHALL cover: write addr 3 = 0x1234, cfg_go (cycle 0) with defaults -> load high cycles 2-3 with choice=3, data=0x1234; pluse_start/done at cycle 5; busy low at cycle 6.
REQ-033 SHALL cover: writes addr 9 = 0xAAAA then addr 2 = 0x5555, cfg_go -> addr 2 streamed before addr 9; exactly 2 load strobes, then 1 pluse_start.
REQ-034 SHALL cover: cfg_go with no writes -> pluse_start at cycle 1, no load strobe.
REQ-035 SHALL cover: host_we during STROBE -> wr_err pulse, table unchanged; a later cfg_go sends nothing new.
REQ-036 SHALL cover: rst_n low during the second STROBE cycle -> all outputs 0 asynchronously; post-release cfg_go yields only pluse_start.
REQ-037 SHALL cover: LOAD_HOLD=1, LOAD_GAP=0 with 16 pending entries -> 16 strobes in ascending order, 2 cycles per entry, then pluse_start.
